// File: rtl/restoring_divider_if.sv
// Operand/result handshake bundle between the PE controller and the restoring divider.
// The controller side (master) drives operands and out_ready; the divider (slave)
// drives in_ready, the result fields and busy.
interface restoring_divider_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             busy;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, busy
    );
endinterface

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per cycle by trial
// subtraction (add of ~divisor with carry-in 1). Operands arrive on a valid/ready
// pair, results leave on a second valid/ready pair and are held until the next result.
module restoring_divider #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst_n,
    restoring_divider_if.slave bus
);
    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;

    // Working registers: partial remainder P, dividend/quotient shift register Q.
    // A restored P is always below the divisor, so WIDTH bits hold it; the extra
    // sign bit only exists inside the trial sum.
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Result registers, separate from the working set so a new accept does not
    // disturb the last result still on the outputs.
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] p_next;
    logic [WIDTH-1:0] q_next;
    logic             accept;
    logic             divisor_zero;

    // Operand acceptance is only possible while idle.
    always_comb begin
        accept       = bus.in_valid && (state_q == IDLE);
        divisor_zero = (bus.divisor == '0);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // pre-edge values regardless of process ordering.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no
        // path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE: if (accept)                 state_d = divisor_zero ? DONE : CALC;
            CALC: if (cnt_q == CNT_LAST)      state_d = DONE;
            DONE: if (bus.out_ready)          state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // One restoring step: shift {P,Q} left, trial-subtract, keep or restore.
    always_comb begin
        shifted = {p_q, q_q[WIDTH-1]};
        trial   = shifted + ~{1'b0, div_q} + {{WIDTH{1'b0}}, 1'b1};
        p_next  = shifted[WIDTH-1:0];
        q_next  = {q_q[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            p_next = trial[WIDTH-1:0];
            q_next = {q_q[WIDTH-2:0], 1'b1};
        end
    end

    // Datapath next values: load on accept, iterate in CALC, capture the result on
    // the final iteration (or immediately for a zero divisor).
    always_comb begin
        p_d   = p_q;
        q_d   = q_q;
        div_d = div_q;
        cnt_d = cnt_q;
        quo_d = quo_q;
        rem_d = rem_q;
        dbz_d = dbz_q;
        if (accept) begin
            div_d = bus.divisor;
            q_d   = bus.dividend;
            p_d   = '0;
            cnt_d = '0;
            dbz_d = divisor_zero;
            if (divisor_zero) begin
                quo_d = '1;
                rem_d = bus.dividend;
            end
        end else if (state_q == CALC) begin
            p_d   = p_next;
            q_d   = q_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
                quo_d = q_next;
                rem_d = p_next;
            end
        end
    end

    // Datapath and result registers; reset aborts any division in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q   <= '0;
            q_q   <= '0;
            div_q <= '0;
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            p_q   <= p_d;
            q_q   <= q_d;
            div_q <= div_d;
            cnt_q <= cnt_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dbz_q <= dbz_d;
        end
    end

    // Outputs: handshakes decoded from state only, results straight from registers.
    always_comb begin
        bus.in_ready    = (state_q == IDLE);
        bus.out_valid   = (state_q == DONE);
        bus.busy        = (state_q != IDLE);
        bus.quotient    = quo_q;
        bus.remainder   = rem_q;
        bus.div_by_zero = dbz_q;
    end
endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: table-driven vectors, hand-written
// multi-cycle sequences and random vectors, all checked through a result scoreboard.
module tb_restoring_divider;
    localparam int WIDTH = 8;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } res_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } vec_t;

    logic clk;
    logic rst_n;

    restoring_divider_if #(.WIDTH(WIDTH)) bus ();

    restoring_divider #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t exp_q[$];
    vec_t vecs[11];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; outputs are sampled and inputs driven here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic res_t model(input logic [7:0] a, input logic [7:0] b);
        res_t e;
        if (b == 8'd0) begin
            e.q   = 8'hFF;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Pop the oldest expected result and compare it with the DUT outputs.
    task automatic compare_out(input string tag);
        res_t e;
        check({tag, "_out_valid"}, bus.out_valid, 1);
        if (exp_q.size() == 0) begin
            check({tag, "_scoreboard_nonempty"}, exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_quotient"},    bus.quotient,    e.q);
            check({tag, "_remainder"},   bus.remainder,   e.r);
            check({tag, "_div_by_zero"}, bus.div_by_zero, e.dbz);
        end
    endtask

    // Present an operand pair, wait for acceptance, push the expected result.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input res_t e, input string tag);
        int guard = 0;
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && guard < 50) begin
            step();
            guard++;
        end
        if (!bus.in_ready) check({tag, "_accept_timeout"}, bus.in_ready, 1);
        step();
        exp_q.push_back(e);
        bus.in_valid = 1'b0;
    endtask

    // Wait for out_valid (latency counted from the accept cycle as cycle 1), optionally
    // hold out_ready low for 'hold' cycles with stray in_valid, then complete the handshake.
    task automatic finish_op(input string tag, input int exp_lat, input int hold);
        int lat = 1;
        while (!bus.out_valid && lat < 40) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.dividend = 8'd1;
            bus.divisor  = 8'd1;
            step();
            check({tag, "_hold_out_valid"}, bus.out_valid, 1);
            check({tag, "_hold_in_ready"},  bus.in_ready,  0);
            if (exp_q.size() != 0) begin
                check({tag, "_hold_quotient"},  bus.quotient,  exp_q[0].q);
                check({tag, "_hold_remainder"}, bus.remainder, exp_q[0].r);
            end
        end
        bus.in_valid = 1'b0;
        compare_out(tag);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, "_out_valid_after_handshake"}, bus.out_valid, 0);
    endtask

    // Back-to-back issue with in_valid held high: second operand only taken in IDLE.
    task automatic back_to_back();
        logic [7:0] as[2];
        logic [7:0] bs[2];
        int         acc_cyc[2];
        int         idx = 0;
        int         got = 0;
        int         cyc = 0;
        logic       acc_now;
        logic       done_now;
        as[0] = 8'd50; bs[0] = 8'd6;
        as[1] = 8'd49; bs[1] = 8'd7;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        bus.out_ready = 1'b1;
        bus.dividend  = as[0];
        bus.divisor   = bs[0];
        bus.in_valid  = 1'b1;
        while (got < 2 && cyc < 60) begin
            acc_now  = bus.in_valid && bus.in_ready;
            done_now = bus.out_valid && bus.out_ready;
            if (done_now) begin
                check("b2b_in_ready_while_done", bus.in_ready, 0);
                compare_out("b2b");
                got++;
            end
            step();
            cyc++;
            if (acc_now) begin
                exp_q.push_back(model(as[idx], bs[idx]));
                acc_cyc[idx] = cyc;
                idx++;
                if (idx < 2) begin
                    bus.dividend = as[idx];
                    bus.divisor  = bs[idx];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("b2b_results_seen", got, 2);
        check("b2b_issue_interval", acc_cyc[1] - acc_cyc[0], WIDTH + 2);
    endtask

    // Reset asserted in the fourth CALC cycle of 77/5, then the same division rerun.
    task automatic reset_mid_op();
        bus.dividend = 8'd77;
        bus.divisor  = 8'd5;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check("rst_busy_before", bus.busy, 1);
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b0;
        #1;
        check("rst_quotient",    bus.quotient,    0);
        check("rst_remainder",   bus.remainder,   0);
        check("rst_div_by_zero", bus.div_by_zero, 0);
        check("rst_out_valid",   bus.out_valid,   0);
        check("rst_busy",        bus.busy,        0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("rst_in_ready_after_release", bus.in_ready, 1);
        for (int i = 0; i < 12; i++) begin
            check("rst_no_partial_result", bus.out_valid, 0);
            step();
        end
        issue(8'd77, 8'd5, model(8'd77, 8'd5), "rst_rerun");
        finish_op("rst_rerun", 9, 0);
    endtask

    initial begin
        res_t e;
        logic [7:0] a;
        logic [7:0] b;

        vecs[0]  = '{a: 8'd3,   b: 8'd10,  q: 8'd0,   r: 8'd3,   dbz: 1'b0};
        vecs[1]  = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,   dbz: 1'b0};
        vecs[2]  = '{a: 8'd0,   b: 8'd9,   q: 8'd0,   r: 8'd0,   dbz: 1'b0};
        vecs[3]  = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2,   dbz: 1'b0};
        vecs[4]  = '{a: 8'd5,   b: 8'd0,   q: 8'hFF,  r: 8'd5,   dbz: 1'b1};
        vecs[5]  = '{a: 8'd6,   b: 8'd3,   q: 8'd2,   r: 8'd0,   dbz: 1'b0};
        vecs[6]  = '{a: 8'd200, b: 8'd9,   q: 8'd22,  r: 8'd2,   dbz: 1'b0};
        vecs[7]  = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,   dbz: 1'b0};
        vecs[8]  = '{a: 8'd254, b: 8'd255, q: 8'd0,   r: 8'd254, dbz: 1'b0};
        vecs[9]  = '{a: 8'd128, b: 8'd2,   q: 8'd64,  r: 8'd0,   dbz: 1'b0};
        vecs[10] = '{a: 8'd0,   b: 8'd0,   q: 8'hFF,  r: 8'd0,   dbz: 1'b1};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;

        // Reset state.
        step();
        step();
        check("reset_out_valid",   bus.out_valid,   0);
        check("reset_busy",        bus.busy,        0);
        check("reset_quotient",    bus.quotient,    0);
        check("reset_remainder",   bus.remainder,   0);
        check("reset_div_by_zero", bus.div_by_zero, 0);
        rst_n = 1'b1;
        step();
        check("reset_in_ready", bus.in_ready, 1);

        // 100/7 with immediate out_ready.
        e = '{q: 8'd14, r: 8'd2, dbz: 1'b0};
        issue(8'd100, 8'd7, e, "t1");
        check("t1_busy", bus.busy, 1);
        finish_op("t1", 9, 0);

        // Divide by zero, then a normal division clears the flag on accept.
        e = '{q: 8'hFF, r: 8'd5, dbz: 1'b1};
        issue(8'd5, 8'd0, e, "t2a");
        finish_op("t2a", 1, 0);
        check("t2_dbz_kept_after_handshake", bus.div_by_zero, 1);
        e = '{q: 8'd2, r: 8'd0, dbz: 1'b0};
        issue(8'd6, 8'd3, e, "t2b");
        check("t2b_dbz_cleared_on_accept", bus.div_by_zero, 0);
        check("t2b_quotient_held_during_calc", bus.quotient, 8'hFF);
        finish_op("t2b", 9, 0);

        // Table-driven vectors.
        for (int i = 0; i < 11; i++) begin
            e = '{q: vecs[i].q, r: vecs[i].r, dbz: vecs[i].dbz};
            issue(vecs[i].a, vecs[i].b, e, $sformatf("vec%0d", i));
            finish_op($sformatf("vec%0d", i), vecs[i].dbz ? 1 : 9, 0);
        end

        // 200/9 under 20 cycles of backpressure with stray in_valid.
        e = '{q: 8'd22, r: 8'd2, dbz: 1'b0};
        issue(8'd200, 8'd9, e, "t4");
        finish_op("t4", 9, 20);
        check("t4_quotient_kept_after_handshake", bus.quotient, 22);

        reset_mid_op();

        back_to_back();

        // Random vectors against the arithmetic model.
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            e = model(a, b);
            issue(a, b, e, "rand");
            finish_op("rand", e.dbz ? 1 : 9, 0);
        end

        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
